ps2_kb_cmd_ctrl: RTL and testbench

- Host-side sequencer for the PS/2 keyboard PHY. Drives its write/write_data strobe, monitors its busy flag, and consumes its read/read_data byte strobe.
- Issues the keyboard reset sequence (0xFF, then ACK 0xFA, then BAT 0xAA) and the LED update sequence (0xED, ACK, LED byte, ACK).
- Handles resend (0xFE) with bounded retries and tick-based timeouts.
- Forwards all non-response bytes to the scan-code consumer.

---
 rtl/ps2_kb_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_ps2_kb_cmd_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kb_cmd_ctrl.sv
// ps2_kb_cmd_ctrl
//   Host-side command sequencer that sits on top of the PS/2 keyboard PHY.
//   It runs the keyboard reset sequence (0xFF -> ACK 0xFA -> BAT 0xAA) and
//   the LED update sequence (0xED -> ACK, LED byte -> ACK). It handles resend
//   requests (0xFE) with a bounded retry count and guards every response wait
//   with a tick-based timeout. Every received byte that is not consumed as a
//   response is forwarded to the scan-code consumer.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   tick            one-cycle timebase strobe (shared with the PHY)
//   init_req        pulse: run the keyboard reset sequence
//   led_req         pulse: run the LED update sequence
//   led_state[2:0]  {caps, num, scroll}, sampled when led_req is accepted
//   phy_busy        PHY busy flag
//   phy_read        PHY received-byte strobe
//   phy_rdata[7:0]  PHY received byte
//   phy_write       PHY transmit request (held until the PHY shows busy)
//   phy_wdata[7:0]  byte to transmit
//   scancode_valid  one-cycle strobe for a forwarded byte
//   scancode[7:0]   forwarded byte
//   busy            a sequence is in progress
//   cmd_done        one-cycle strobe: sequence completed
//   cmd_err         one-cycle strobe: sequence failed
module ps2_kb_cmd_ctrl #(
    parameter int TIMEOUT_TICKS = 1023,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       init_req,
    input  logic       led_req,
    input  logic [2:0] led_state,
    input  logic       phy_busy,
    input  logic       phy_read,
    input  logic [7:0] phy_rdata,
    output logic       phy_write,
    output logic [7:0] phy_wdata,
    output logic       scancode_valid,
    output logic [7:0] scancode,
    output logic       busy,
    output logic       cmd_done,
    output logic       cmd_err
);

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
    localparam logic [7:0] RSP_BAT_ERR = 8'hFC;

    // +2 keeps the counter at least one bit wide even for MAX_RETRY=0.
    localparam int              RW        = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0]   RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [9:0]      TMO_LAST  = 10'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, DONE, ERR
    } state_t;

    state_t          state, state_nxt;
    logic            boot_pend, boot_nxt;   // self-issued init after reset
    logic            is_init, init_nxt;     // current list is the reset list
    logic            idx, idx_nxt;          // 0: command byte, 1: LED argument
    logic [7:0]      led_byte, led_nxt;
    logic [RW-1:0]   retry, retry_nxt;
    logic [9:0]      tmo, tmo_nxt;
    logic            write_nxt;
    logic [7:0]      wdata_nxt;
    logic [7:0]      cur_byte;
    logic            rsp_consumed;
    logic            tmo_hit;

    assign cur_byte = idx ? led_byte : (is_init ? CMD_RESET : CMD_SET_LED);

    // Response bytes are swallowed only in the state that expects them;
    // anywhere else they reach the scan-code consumer like any other byte.
    always_comb begin
        rsp_consumed = 1'b0;
        if (state == WAIT_ACK)
            rsp_consumed = (phy_rdata == RSP_ACK) || (phy_rdata == RSP_RESEND);
        else if (state == WAIT_BAT)
            rsp_consumed = (phy_rdata == RSP_BAT_OK) || (phy_rdata == RSP_BAT_ERR);
    end

    // A received byte in the same cycle as the terminal tick suppresses the
    // timeout, so a late but valid answer is still honoured.
    assign tmo_hit = tick && !phy_read && (tmo == TMO_LAST);

    assign busy     = (state != IDLE);
    assign cmd_done = (state == DONE);
    assign cmd_err  = (state == ERR);

    always_comb begin
        state_nxt = state;
        write_nxt = phy_write;
        wdata_nxt = phy_wdata;
        boot_nxt  = boot_pend;
        init_nxt  = is_init;
        idx_nxt   = idx;
        led_nxt   = led_byte;
        retry_nxt = retry;
        tmo_nxt   = tmo;
        case (state)
            IDLE: begin
                if (boot_pend || init_req) begin
                    boot_nxt  = 1'b0;
                    init_nxt  = 1'b1;
                    idx_nxt   = 1'b0;
                    retry_nxt = '0;
                    state_nxt = SEND;
                end else if (led_req) begin
                    init_nxt  = 1'b0;
                    idx_nxt   = 1'b0;
                    retry_nxt = '0;
                    led_nxt   = {5'b0, led_state};
                    state_nxt = SEND;
                end
            end
            SEND: begin
                // Request only once the PHY is idle; release it as soon as
                // the PHY acknowledges by raising busy.
                if (!phy_write) begin
                    if (!phy_busy) begin
                        write_nxt = 1'b1;
                        wdata_nxt = cur_byte;
                    end
                end else if (phy_busy) begin
                    write_nxt = 1'b0;
                    state_nxt = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (!phy_busy) begin
                    tmo_nxt   = '0;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (phy_read && phy_rdata == RSP_ACK) begin
                    retry_nxt = '0;
                    if (is_init) begin
                        tmo_nxt   = '0;
                        state_nxt = WAIT_BAT;
                    end else if (idx) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = 1'b1;
                        state_nxt = SEND;
                    end
                end else if (phy_read && phy_rdata == RSP_RESEND) begin
                    if (retry < RETRY_LIM) begin
                        retry_nxt = retry + 1'b1;
                        state_nxt = SEND;
                    end else begin
                        state_nxt = ERR;
                    end
                end else if (tick && !phy_read) begin
                    tmo_nxt = tmo + 1'b1;
                    if (tmo_hit) state_nxt = ERR;
                end
            end
            WAIT_BAT: begin
                if (phy_read && phy_rdata == RSP_BAT_OK) begin
                    state_nxt = DONE;
                end else if (phy_read && phy_rdata == RSP_BAT_ERR) begin
                    state_nxt = ERR;
                end else if (tick && !phy_read) begin
                    tmo_nxt = tmo + 1'b1;
                    if (tmo_hit) state_nxt = ERR;
                end
            end
            DONE: begin
                tmo_nxt   = '0;
                state_nxt = IDLE;
            end
            ERR: begin
                retry_nxt = '0;
                tmo_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            boot_pend <= 1'b1;
            is_init   <= 1'b0;
            idx       <= 1'b0;
            led_byte  <= 8'h00;
            retry     <= '0;
            tmo       <= '0;
            phy_write <= 1'b0;
            phy_wdata <= 8'h00;
        end else begin
            state     <= state_nxt;
            boot_pend <= boot_nxt;
            is_init   <= init_nxt;
            idx       <= idx_nxt;
            led_byte  <= led_nxt;
            retry     <= retry_nxt;
            tmo       <= tmo_nxt;
            phy_write <= write_nxt;
            phy_wdata <= wdata_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scancode_valid <= 1'b0;
            scancode       <= 8'h00;
        end else begin
            scancode_valid <= phy_read && !rsp_consumed;
            if (phy_read && !rsp_consumed) scancode <= phy_rdata;
        end
    end

endmodule

// File: tb/tb_ps2_kb_cmd_ctrl.sv
module tb_ps2_kb_cmd_ctrl;

    localparam int TIMEOUT_TICKS = 1023;
    localparam int TX_CYC        = 5;
    localparam int BOUND         = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       init_req = 1'b0;
    logic       led_req = 1'b0;
    logic [2:0] led_state = 3'b000;
    logic       phy_busy = 1'b0;
    logic       phy_read = 1'b0;
    logic [7:0] phy_rdata = 8'h00;
    logic       phy_write;
    logic [7:0] phy_wdata;
    logic       scancode_valid;
    logic [7:0] scancode;
    logic       busy;
    logic       cmd_done;
    logic       cmd_err;

    ps2_kb_cmd_ctrl #(.TIMEOUT_TICKS(TIMEOUT_TICKS), .MAX_RETRY(3)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .init_req(init_req),
        .led_req(led_req), .led_state(led_state), .phy_busy(phy_busy),
        .phy_read(phy_read), .phy_rdata(phy_rdata), .phy_write(phy_write),
        .phy_wdata(phy_wdata), .scancode_valid(scancode_valid),
        .scancode(scancode), .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // observation logs
    logic [7:0] wr_log[$];
    logic [7:0] fwd_log[$];
    int n_tx = 0, n_done = 0, n_err = 0, n_idle = 0;

    // results of the last run_seq
    logic [7:0] act_w[$], act_fwd[$], mdl_w[$], mdl_fwd[$];
    int act_done, act_err, act_idle, mdl_done, mdl_err;
    logic [7:0] scr[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // tick every 4th cycle
    initial begin
        int tc;
        tc = 0;
        forever begin
            @(posedge clk); #1;
            tc = (tc + 1) % 4;
            tick = (tc == 0);
        end
    end

    // PHY model: accepts a write when idle, stays busy TX_CYC cycles
    initial begin
        forever begin
            @(posedge clk); #1;
            if (phy_write && !phy_busy) begin
                wr_log.push_back(phy_wdata);
                phy_busy = 1'b1;
                repeat (TX_CYC) @(posedge clk);
                #1;
                phy_busy = 1'b0;
                n_tx++;
            end
        end
    end

    // output monitor
    always @(negedge clk) begin
        if (cmd_done) n_done++;
        if (cmd_err) n_err++;
        if (scancode_valid) fwd_log.push_back(scancode);
        if (!busy) n_idle++;
    end

    // deliver one byte; report the scan-code outputs one cycle later
    task automatic deliver(input logic [7:0] b, output logic v, output logic [7:0] sc);
        @(posedge clk); #1;
        phy_read  = 1'b1;
        phy_rdata = b;
        @(posedge clk); #1;
        phy_read  = 1'b0;
        @(negedge clk);
        v  = scancode_valid;
        sc = scancode;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < BOUND) begin @(posedge clk); #1; c++; end
        if (c >= BOUND) fail_now("wait_idle");
    endtask

    // Runs one command sequence, answering from scr[] (or randomly), and
    // predicts writes/forwards/outcome from the protocol rules.
    task automatic run_seq(input bit init, input bit boot, input bit both,
                           input logic [2:0] led, input bit rnd);
        int wb, fb, db, eb, tb, ib, retry, nb, c, r;
        bit fin, bat, second, abort;
        logic [7:0] b, lb, sc;
        logic v;
        lb = {5'b0, led};
        mdl_w.delete(); mdl_fwd.delete(); mdl_done = 0; mdl_err = 0;
        mdl_w.push_back(init ? 8'hFF : 8'hED);
        retry = 0; nb = 0; fin = 0; bat = 0; second = 0; abort = 0;
        if (!boot) begin
            wait_idle();
            @(posedge clk); #1;
            led_state = led;
            if (init || both) init_req = 1'b1;
            if (!init || both) led_req = 1'b1;
            @(posedge clk); #1;
            init_req = 1'b0;
            led_req  = 1'b0;
        end
        wb = wr_log.size(); fb = fwd_log.size(); db = n_done; eb = n_err;
        tb = n_tx; ib = n_idle;
        while (!fin && !abort) begin
            if (rnd) begin
                if (nb >= 16) b = bat ? 8'hFC : 8'hFE;
                else begin
                    r = $urandom_range(0, 9);
                    case (r)
                        0, 1, 2, 3: b = 8'hFA;
                        4, 5:       b = 8'hFE;
                        6:          b = 8'hAA;
                        7:          b = 8'hFC;
                        default:    b = 8'($urandom_range(0, 255));
                    endcase
                end
            end else begin
                if (nb >= scr.size()) break;
                b = scr[nb];
            end
            c = 0;
            while (n_tx - tb < mdl_w.size() && c < BOUND) begin
                @(posedge clk); #1; c++;
            end
            if (c >= BOUND) begin fail_now("tx_wait"); abort = 1; end
            else begin
                if (nb == 0) ib = n_idle;
                nb++;
                repeat (3) @(posedge clk);
                deliver(b, v, sc);
                if (!bat) begin
                    if (b == 8'hFA) begin
                        retry = 0;
                        if (init) bat = 1;
                        else if (second) begin mdl_done = 1; fin = 1; end
                        else begin second = 1; mdl_w.push_back(lb); end
                    end else if (b == 8'hFE) begin
                        if (retry < 3) begin retry++; mdl_w.push_back(mdl_w[mdl_w.size()-1]); end
                        else begin mdl_err = 1; fin = 1; end
                    end else mdl_fwd.push_back(b);
                end else begin
                    if (b == 8'hAA) begin mdl_done = 1; fin = 1; end
                    else if (b == 8'hFC) begin mdl_err = 1; fin = 1; end
                    else mdl_fwd.push_back(b);
                end
            end
        end
        c = 0;
        while ((n_done - db) + (n_err - eb) == 0 && c < BOUND) begin
            @(posedge clk); #1; c++;
        end
        if (c >= BOUND) fail_now("end_wait");
        act_idle = n_idle - ib;
        act_done = n_done - db;
        act_err  = n_err - eb;
        act_w.delete(); act_fwd.delete();
        for (int i = wb; i < wr_log.size(); i++) act_w.push_back(wr_log[i]);
        for (int i = fb; i < fwd_log.size(); i++) act_fwd.push_back(fwd_log[i]);
    endtask

    task automatic cmp_model(input string tag);
        check({tag, "_nw"}, act_w.size(), mdl_w.size());
        for (int i = 0; i < act_w.size() && i < mdl_w.size(); i++)
            check($sformatf("%s_w%0d", tag, i), act_w[i], mdl_w[i]);
        check({tag, "_nfwd"}, act_fwd.size(), mdl_fwd.size());
        for (int i = 0; i < act_fwd.size() && i < mdl_fwd.size(); i++)
            check($sformatf("%s_f%0d", tag, i), act_fwd[i], mdl_fwd[i]);
        check({tag, "_done"}, act_done, mdl_done);
        check({tag, "_err"}, act_err, mdl_err);
        check({tag, "_busy"}, act_idle, 0);
    endtask

    typedef struct {
        bit         init;
        logic [2:0] led;
        int         n;
        logic [7:0] s[6];
        int         nw;
        logic [7:0] w[5];
        int         nfwd;
        int         done;
        int         err;
    } vec_t;

    initial begin
        vec_t tbl[8];
        logic v;
        logic [7:0] sc;
        int c, n, ini;
        logic [2:0] ls;

        tbl[0] = '{1'b0, 3'b101, 2, '{8'hFA, 8'hFA, 0, 0, 0, 0}, 2, '{8'hED, 8'h05, 0, 0, 0}, 0, 1, 0};
        tbl[1] = '{1'b0, 3'b010, 4, '{8'hFE, 8'hFE, 8'hFA, 8'hFA, 0, 0}, 4, '{8'hED, 8'hED, 8'hED, 8'h02, 0}, 0, 1, 0};
        tbl[2] = '{1'b0, 3'b111, 4, '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 0, 0}, 4, '{8'hED, 8'hED, 8'hED, 8'hED, 0}, 0, 0, 1};
        tbl[3] = '{1'b1, 3'b000, 2, '{8'hFA, 8'hAA, 0, 0, 0, 0}, 1, '{8'hFF, 0, 0, 0, 0}, 0, 1, 0};
        tbl[4] = '{1'b1, 3'b000, 2, '{8'hFA, 8'hFC, 0, 0, 0, 0}, 1, '{8'hFF, 0, 0, 0, 0}, 0, 0, 1};
        tbl[5] = '{1'b1, 3'b000, 4, '{8'hFE, 8'hFA, 8'h55, 8'hAA, 0, 0}, 2, '{8'hFF, 8'hFF, 0, 0, 0}, 1, 1, 0};
        tbl[6] = '{1'b0, 3'b001, 4, '{8'hFA, 8'h12, 8'hFE, 8'hFA, 0, 0}, 3, '{8'hED, 8'h01, 8'h01, 0, 0}, 1, 1, 0};
        tbl[7] = '{1'b0, 3'b100, 5, '{8'hFA, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 0}, 5, '{8'hED, 8'h04, 8'h04, 8'h04, 8'h04}, 0, 0, 1};

        // reset values
        repeat (3) @(negedge clk);
        check("rst_phy_write", phy_write, 0);
        check("rst_phy_wdata", phy_wdata, 0);
        check("rst_sc_valid", scancode_valid, 0);
        check("rst_scancode", scancode, 0);
        check("rst_busy", busy, 0);
        check("rst_done", cmd_done, 0);
        check("rst_err", cmd_err, 0);

        // self-issued init after reset release
        scr = '{8'hFA, 8'hAA};
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_seq(1, 1, 0, 3'b000, 0);
        check("boot_nw", act_w.size(), 1);
        if (act_w.size() > 0) check("boot_w0", act_w[0], 8'hFF);
        check("boot_done", act_done, 1);
        check("boot_err", act_err, 0);
        check("boot_nfwd", act_fwd.size(), 0);
        check("boot_busy", act_idle, 0);

        // table-driven sequences
        for (int i = 0; i < 8; i++) begin
            scr.delete();
            for (int k = 0; k < tbl[i].n; k++) scr.push_back(tbl[i].s[k]);
            run_seq(tbl[i].init, 0, 0, tbl[i].led, 0);
            check($sformatf("tbl%0d_nw", i), act_w.size(), tbl[i].nw);
            for (int k = 0; k < tbl[i].nw && k < act_w.size(); k++)
                check($sformatf("tbl%0d_w%0d", i, k), act_w[k], tbl[i].w[k]);
            check($sformatf("tbl%0d_nfwd", i), act_fwd.size(), tbl[i].nfwd);
            check($sformatf("tbl%0d_done", i), act_done, tbl[i].done);
            check($sformatf("tbl%0d_err", i), act_err, tbl[i].err);
            check($sformatf("tbl%0d_busy", i), act_idle, 0);
        end

        // forwarding latency in IDLE and during WAIT_ACK
        wait_idle();
        deliver(8'h1C, v, sc);
        check("idle_fwd_valid", v, 1);
        check("idle_fwd_byte", sc, 8'h1C);
        @(negedge clk);
        check("idle_fwd_pulse", scancode_valid, 0);
        c = n_tx;
        @(posedge clk); #1;
        led_req = 1'b1; led_state = 3'b000;
        @(posedge clk); #1;
        led_req = 1'b0;
        n = 0;
        while (n_tx == c && n < BOUND) begin @(posedge clk); #1; n++; end
        if (n >= BOUND) fail_now("fwd_tx_wait");
        repeat (3) @(posedge clk);
        deliver(8'hF0, v, sc);
        check("ack_fwd_valid", v, 1);
        check("ack_fwd_byte", sc, 8'hF0);
        deliver(8'hFA, v, sc);
        check("ack_consumed", v, 0);
        n = 0;
        while (n_tx < c + 2 && n < BOUND) begin @(posedge clk); #1; n++; end
        if (n >= BOUND) fail_now("fwd_tx2_wait");
        c = n_done;
        repeat (3) @(posedge clk);
        deliver(8'hFA, v, sc);
        check("ack2_consumed", v, 0);
        @(posedge clk); #1;
        check("fwd_seq_done", n_done - c, 1);

        // init and led requested together: init wins
        scr = '{8'hFA, 8'hAA};
        run_seq(1, 0, 1, 3'b011, 0);
        cmp_model("both");

        // reset mid-sequence drops phy_write at once, init restarts
        wait_idle();
        @(posedge clk); #1;
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        n = 0;
        while (!phy_write && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) fail_now("midrst_wait");
        rst_n = 1'b0;
        #1;
        check("midrst_write", phy_write, 0);
        check("midrst_busy", busy, 0);
        repeat (TX_CYC + 10) @(posedge clk);
        #1;
        scr = '{8'hFA, 8'hAA};
        rst_n = 1'b1;
        run_seq(1, 1, 0, 3'b000, 0);
        cmp_model("reboot");

        // timeout: no answer after 0xFF
        wait_idle();
        c = n_err;
        @(posedge clk); #1;
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        n = 0;
        while (!phy_busy && n < BOUND) begin @(negedge clk); n++; end
        while (phy_busy && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) fail_now("tmo_tx_wait");
        // this negedge is the cycle in which busy fell; count from the next
        n = 0;
        begin
            int guard;
            guard = 0;
            forever begin
                @(negedge clk);
                guard++;
                if (cmd_err) break;
                if (tick) n++;
                if (guard > TIMEOUT_TICKS * 4 + 100) break;
            end
        end
        check("tmo_err_seen", cmd_err, 1);
        check("tmo_ticks", n, TIMEOUT_TICKS);
        @(posedge clk); #1;
        check("tmo_err_count", n_err - c, 1);

        // randomized sequences against the model
        for (int it = 0; it < 12; it++) begin
            ini = $urandom_range(0, 1);
            ls  = 3'($urandom_range(0, 7));
            run_seq(ini[0], 0, 0, ls, 1);
            cmp_model($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
